// File: rtl/pll_drp_pkg.sv
// Shared constants, state encoding and divider-field helper for the PLLE2 DRP master.
// Latency: n/a (package only).
// Backpressure: n/a.
package pll_drp_pkg;

    // DRP addresses of the clock registers touched by a reconfiguration
    localparam logic [6:0] FB_REG1 = 7'h14;
    localparam logic [6:0] FB_REG2 = 7'h15;
    localparam logic [6:0] O0_REG1 = 7'h08;
    localparam logic [6:0] O0_REG2 = 7'h09;

    // Bits preserved from the read-back value during read-modify-write
    localparam logic [15:0] KEEP_REG1 = 16'hF000;
    localparam logic [15:0] KEEP_REG2 = 16'hFF3F;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RST_WAIT,
        ST_RD,
        ST_RD_WAIT,
        ST_WR,
        ST_WR_WAIT,
        ST_RELEASE,
        ST_LOCK_WAIT,
        ST_FINISH
    } state_e;

    typedef struct packed {
        logic [15:0] reg1;
        logic [15:0] reg2;
    } div_regs_t;

    // High/low counts, edge and no_count bits for a divide value d (1..64).
    // Low time is computed modulo 64, which is exact because it never exceeds 32.
    function automatic div_regs_t div_to_regs(input logic [6:0] d);
        logic [5:0] hi;
        logic [5:0] lo;
        div_regs_t  r;
        hi     = d[6:1];
        lo     = d[5:0] - hi;
        r.reg1 = {4'b0000, hi, lo};
        r.reg2 = {8'h00, d[0], (d == 7'd1), 6'b000000};
        return r;
    endfunction

    // Register index 0..3 maps onto the fixed programming order
    function automatic logic [6:0] reg_addr(input logic [1:0] idx);
        logic [6:0] a;
        case (idx)
            2'd0:    a = FB_REG1;
            2'd1:    a = FB_REG2;
            2'd2:    a = O0_REG1;
            default: a = O0_REG2;
        endcase
        return a;
    endfunction

    function automatic logic [15:0] keep_mask(input logic [1:0] idx);
        return idx[0] ? KEEP_REG2 : KEEP_REG1;
    endfunction

endpackage

// File: rtl/pll_drp_ctrl.sv
// DRP master: reprograms PLLE2 CLKFBOUT mult and CLKOUT0 divide, then waits for lock.
// Latency: 1 + RST_HOLD + 4 cycles per register (plus DRP wait) + release + sync + finish.
// Backpressure: one DRP access outstanding at a time; req ignored unless idle.
module pll_drp_ctrl
    import pll_drp_pkg::*;
#(
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int RST_HOLD     = 4
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        req,
    input  logic [6:0]  mult,
    input  logic [6:0]  div,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [6:0]  daddr,
    output logic        den,
    output logic        dwe,
    output logic [15:0] di,
    input  logic [15:0] do_in,
    input  logic        drdy,
    input  logic        locked,
    output logic        pll_rst
);

    localparam logic [15:0] RST_LIM  = 16'(RST_HOLD - 1);
    localparam logic [15:0] DRDY_LIM = 16'(DRDY_TIMEOUT - 1);
    localparam logic [15:0] LOCK_LIM = 16'(LOCK_TIMEOUT - 1);

    state_e      state_q;
    logic [1:0]  idx_q;
    logic [15:0] cnt_q;
    logic [6:0]  mult_q;
    logic [6:0]  div_q;
    logic        lock_meta_q;
    logic        lock_sync_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic [6:0]  daddr_q;
    logic        den_q;
    logic        dwe_q;
    logic [15:0] di_q;
    logic        pll_rst_q;

    logic        args_ok_d;
    div_regs_t   regs_d;
    logic [15:0] field_d;
    logic [15:0] wr_dat_d;
    logic [1:0]  idx_nxt_d;

    // Argument check and merge of read-back data with the new divider fields
    always_comb begin
        args_ok_d = (mult >= 7'd2) && (mult <= 7'd64) && (div >= 7'd1) && (div <= 7'd64);
        regs_d    = div_to_regs(idx_q[1] ? div_q : mult_q);
        field_d   = idx_q[0] ? regs_d.reg2 : regs_d.reg1;
        wr_dat_d  = (do_in & keep_mask(idx_q)) | field_d;
        idx_nxt_d = idx_q + 2'd1;
    end

    // Two-flop synchroniser for the PLL's asynchronous LOCKED
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    // Sequencer; DRP strobes are set on entry to RD/WR so they last one cycle
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            cnt_q     <= 16'd0;
            mult_q    <= 7'd0;
            div_q     <= 7'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            daddr_q   <= 7'd0;
            den_q     <= 1'b0;
            dwe_q     <= 1'b0;
            di_q      <= 16'd0;
            pll_rst_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            den_q  <= 1'b0;
            dwe_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (args_ok_d) begin
                            mult_q    <= mult;
                            div_q     <= div;
                            error_q   <= 1'b0;
                            busy_q    <= 1'b1;
                            pll_rst_q <= 1'b1;
                            idx_q     <= 2'd0;
                            cnt_q     <= 16'd0;
                            state_q   <= ST_RST_WAIT;
                        end else begin
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_RST_WAIT: begin
                    if (cnt_q == RST_LIM) begin
                        daddr_q <= reg_addr(idx_q);
                        den_q   <= 1'b1;
                        state_q <= ST_RD;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_RD: begin
                    cnt_q   <= 16'd0;
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (drdy) begin
                        di_q    <= wr_dat_d;
                        den_q   <= 1'b1;
                        dwe_q   <= 1'b1;
                        state_q <= ST_WR;
                    end else if (cnt_q == DRDY_LIM) begin
                        error_q   <= 1'b1;
                        pll_rst_q <= 1'b0;
                        state_q   <= ST_FINISH;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_WR: begin
                    cnt_q   <= 16'd0;
                    state_q <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (drdy) begin
                        if (idx_q == 2'd3) begin
                            state_q <= ST_RELEASE;
                        end else begin
                            idx_q   <= idx_nxt_d;
                            daddr_q <= reg_addr(idx_nxt_d);
                            den_q   <= 1'b1;
                            state_q <= ST_RD;
                        end
                    end else if (cnt_q == DRDY_LIM) begin
                        error_q   <= 1'b1;
                        pll_rst_q <= 1'b0;
                        state_q   <= ST_FINISH;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_RELEASE: begin
                    pll_rst_q <= 1'b0;
                    cnt_q     <= 16'd0;
                    state_q   <= ST_LOCK_WAIT;
                end
                ST_LOCK_WAIT: begin
                    if (lock_sync_q) begin
                        state_q <= ST_FINISH;
                    end else if (cnt_q == LOCK_LIM) begin
                        error_q <= 1'b1;
                        state_q <= ST_FINISH;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;
    assign daddr   = daddr_q;
    assign den     = den_q;
    assign dwe     = dwe_q;
    assign di      = di_q;
    assign pll_rst = pll_rst_q;

endmodule
